// File: rtl/stream_packer.sv
// stream_packer: packs Ratio consecutive DataWidth-bit elements into one wide
// word on a registered valid/ready output. last_i closes a partial word early;
// strb_o marks which lanes carry elements.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 synchronous clear of lane counter and output word
//   data_i, last_i, valid_i narrow input element, packet end, valid
//   ready_o                 input accepted this cycle (depends on ready_i only)
//   data_o, strb_o, last_o  wide word, lane strobes, closed-by-last flag
//   valid_o, ready_i        output handshake
//
// Build option: define STREAM_PACKER_ZERO_PAD_EN to force lanes with a clear
// strobe to read as zero; otherwise those lanes carry stale staging content.
module stream_packer #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Ratio     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       last_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [DataWidth*Ratio-1:0] data_o,
    output logic [Ratio-1:0]           strb_o,
    output logic                       last_o,
    output logic                       valid_o,
    input  logic                       ready_i
);

    localparam int unsigned CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned WordW = DataWidth * Ratio;

    logic [CntW-1:0]                     cnt_q,   cnt_d;
    logic [Ratio-2:0][DataWidth-1:0]     stage_q, stage_d;
    logic [WordW-1:0]                    data_q,  data_d;
    logic [Ratio-1:0]                    strb_q,  strb_d;
    logic                                last_q,  last_d;
    logic                                valid_q, valid_d;

    logic             accept_c;
    logic             closing_c;
    logic [WordW-1:0] word_c;
    logic [Ratio-1:0] strb_c;

    // Ready only looks at the output register and the consumer.
    assign ready_o   = !valid_q || ready_i;
    assign accept_c  = valid_i && ready_o && !flush_i;
    assign closing_c = accept_c && (last_i || (cnt_q == CntW'(Ratio - 1)));

    // Candidate word: staged lanes below cnt, new element at lane cnt.
    always_comb begin
        word_c = '0;
        strb_c = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            strb_c[k] = (CntW'(k) <= cnt_q);
        end
        for (int unsigned k = 0; k < Ratio - 1; k++) begin
            word_c[k*DataWidth +: DataWidth] =
                (CntW'(k) == cnt_q) ? data_i : stage_q[k];
        end
        // The top lane is only ever strobed as the closing element.
        word_c[(Ratio-1)*DataWidth +: DataWidth] = data_i;
`ifdef STREAM_PACKER_ZERO_PAD_EN
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (!strb_c[k]) begin
                word_c[k*DataWidth +: DataWidth] = '0;
            end
        end
`endif
    end

    // Next-state: flush wins, then retire, then accept (a new word overrides retire).
    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (flush_i) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (closing_c) begin
                data_d  = word_c;
                strb_d  = strb_c;
                last_d  = last_i;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else if (accept_c) begin
                for (int unsigned k = 0; k < Ratio - 1; k++) begin
                    if (CntW'(k) == cnt_q) begin
                        stage_d[k] = data_i;
                    end
                end
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            stage_q <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign strb_o  = strb_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer (DataWidth=8, Ratio=4).
module tb_stream_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        last_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic [3:0]  strb_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    stream_packer #(.DataWidth(8), .Ratio(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .strb_o  (strb_o),
        .last_o  (last_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one element for one clock edge, then sample 1 time unit later.
    task automatic beat(input logic [7:0] d, input logic l);
        data_i  = d;
        last_i  = l;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        last_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_strb",  64'(strb_o),  64'd0);
        check("rst_last",  64'(last_o),  64'd0);
        check("rst_data",  64'(data_o),  64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        #4 rst_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Full word
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        check("full_ready", 64'(ready_o), 64'd1);
        beat(8'h44, 1'b0);
        check("full_valid", 64'(valid_o), 64'd1);
        check("full_data",  64'(data_o),  64'h44332211);
        check("full_strb",  64'(strb_o),  64'hF);
        check("full_last",  64'(last_o),  64'd0);
        idle();
        check("full_retire", 64'(valid_o), 64'd0);

        // Partial close by last_i
        beat(8'hA1, 1'b0);
        beat(8'hB2, 1'b1);
        check("part_valid", 64'(valid_o),      64'd1);
        check("part_strb",  64'(strb_o),       64'h3);
        check("part_last",  64'(last_o),       64'd1);
        check("part_low",   64'(data_o[15:0]), 64'hB2A1);
`ifdef STREAM_PACKER_ZERO_PAD_EN
        check("part_pad",   64'(data_o[31:16]), 64'h0);
`endif
        idle();

        // Backpressure: word held, next first beat waits at the input
        ready_i = 1'b0;
        beat(8'h51, 1'b0);
        beat(8'h52, 1'b0);
        beat(8'h53, 1'b0);
        beat(8'h54, 1'b0);
        data_i = 8'h61;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(valid_o), 64'd1);
            check("bp_ready", 64'(ready_o), 64'd0);
            check("bp_data",  64'(data_o),  64'h54535251);
            check("bp_strb",  64'(strb_o),  64'hF);
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        beat(8'h61, 1'b0);
        check("bp_retire", 64'(valid_o), 64'd0);
        beat(8'h62, 1'b0);
        beat(8'h63, 1'b0);
        beat(8'h64, 1'b0);
        check("bp_next_valid", 64'(valid_o), 64'd1);
        check("bp_next_data",  64'(data_o),  64'h64636261);
        idle();

        // Back-to-back: 12 beats, 3 words, ready_o never drops
        for (int i = 0; i < 12; i++) begin
            check("b2b_ready", 64'(ready_o), 64'd1);
            beat(8'(128 + i), 1'b0);
            if (i % 4 == 3) begin
                check("b2b_valid", 64'(valid_o), 64'd1);
                check("b2b_data", 64'(data_o),
                      64'({8'(128 + i), 8'(127 + i), 8'(126 + i), 8'(125 + i)}));
            end else begin
                check("b2b_gap", 64'(valid_o), 64'd0);
            end
        end
        idle();

        // Flush mid-word; the beat offered during flush must be dropped
        beat(8'hEE, 1'b0);
        beat(8'hEF, 1'b0);
        flush_i = 1'b1;
        beat(8'h99, 1'b0);
        flush_i = 1'b0;
        check("flush_valid", 64'(valid_o), 64'd0);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        check("flush_data", 64'(data_o), 64'h04030201);
        check("flush_strb", 64'(strb_o), 64'hF);
        idle();

        // last_i on the fourth element: full strobe with last
        beat(8'hD1, 1'b0);
        beat(8'hD2, 1'b0);
        beat(8'hD3, 1'b0);
        beat(8'hD4, 1'b1);
        check("fulllast_strb", 64'(strb_o), 64'hF);
        check("fulllast_last", 64'(last_o), 64'd1);
        check("fulllast_data", 64'(data_o), 64'hD4D3D2D1);
        idle();

        // Asynchronous reset between edges while a word is held
        ready_i = 1'b0;
        beat(8'h71, 1'b0);
        beat(8'h72, 1'b1);
        valid_i = 1'b0;
        last_i  = 1'b0;
        check("arst_pre_valid", 64'(valid_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_strb",  64'(strb_o),  64'd0);
        check("arst_last",  64'(last_o),  64'd0);
        #1 rst_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b0);
        check("arst_resume", 64'(data_o), 64'hC4C3C2C1);
        check("arst_resume_strb", 64'(strb_o), 64'hF);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
# stream_packer

Downstream consumer of the passthrough stream FIFO: takes narrow `DataWidth`-bit elements from the FIFO's output handshake and packs `Ratio` consecutive elements into one wide word, presented on a registered valid/ready output. A `last_i` marker closes a partial word early, and a per-lane strobe marks which lanes are valid. It sits between the FIFO read port and wide consumers such as memory write ports or bus adapters.

## Interface
- `DataWidth`, 8: width of one input element.
- `Ratio`, 4: elements per output word; legal range 2..16.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous clear of staging and output register.
- `data_i`  in  DataWidth  input element.
- `last_i`  in  1  element is the final one of a packet; closes the current word.
- `valid_i`  in  1  input element valid.
- `ready_o`  out  1  block accepts the element this cycle.
- `data_o`  out  DataWidth*Ratio  packed word; lane k is `[k*DataWidth +: DataWidth]`.
- `strb_o`  out  Ratio  bit k set when lane k holds a valid element.
- `last_o`  out  1  word was closed by `last_i`.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  consumer accepts the word.

## Operation
- State: lane counter `cnt` (0..Ratio-1, width `$clog2(Ratio)`), staging buffer of Ratio-1 lanes, output register (data, strb, last, valid).
- Input beat accepted when `valid_i && ready_o`; `ready_o = !valid_o || ready_i`. `ready_o` depends on no input other than `ready_i`.
- Accepted beat, not closing: written to staging lane `cnt`; `cnt <= cnt+1`.
- Closing beat (`cnt == Ratio-1`, or `last_i`): staging lanes 0..cnt-1 plus the new element at lane `cnt` load into the output register; `strb <= (1 << (cnt+1)) - 1`; `last <= last_i`; `valid_o <= 1`; `cnt <= 0`.
- Output word retired when `valid_o && ready_i`; `valid_o` clears unless a closing beat loads a new word in the same cycle, in which case the new word replaces it.
- `data_o`, `strb_o`, `last_o` are stable while `valid_o && !ready_i`.
- `flush_i`: `cnt <= 0`, `valid_o <= 0`; staging content is discarded. `flush_i` has priority over any same-cycle handshake, and no beat is accepted in that cycle.
- `valid_i` with `last_i` on a full word (`cnt == Ratio-1`): produces full strobe with `last_o = 1`.
- Reset values: `valid_o = 0`, `last_o = 0`, `strb_o = 0`, `data_o = 0`, `cnt = 0`. `ready_o = 1` out of reset.
- Reset asserted mid-word: all partial elements are lost and there is no output.

## Timing
- Latency: word appears on `valid_o` one cycle after its closing beat is accepted.
- Throughput: one element per cycle while `ready_i` is high, so a full word takes Ratio input cycles.
- While `valid_o && !ready_i`: `ready_o = 0`, the input stalls, and `cnt` and staging hold.
- No combinational path from `valid_i`/`data_i`/`last_i` to any output.

## Configuration
- `STREAM_PACKER_ZERO_PAD_EN` defined: lanes with `strb_o` bit clear read as zero in `data_o`.
- Not defined: lanes with clear strobe hold whatever the staging register last contained (don't-care to consumers), which saves the mask logic.

## Test plan
- Full word: DataWidth=8, Ratio=4, `ready_i=1`, beats 0x11,0x22,0x33,0x44 with no `last_i` -> one cycle after the fourth beat: `data_o=0x44332211`, `strb_o=4'b1111`, `last_o=0`, `valid_o` high for one cycle.
- Partial close: beats 0xA1,0xB2 with `last_i` on 0xB2 -> `strb_o=4'b0011`, `last_o=1`, lower half `0xB2A1`. Upper half is 0x0000 with `STREAM_PACKER_ZERO_PAD_EN`; without it, the upper half is unchecked.
- Backpressure: hold `ready_i=0` after a word forms -> `ready_o=0`; outputs stable for 5 cycles; releasing `ready_i` retires the word, the next word follows with no loss, and ordering matches.
- Back-to-back: continuous `valid_i` with `ready_i=1` for 12 beats -> 3 words on consecutive 4-cycle boundaries, with no bubble on `ready_o`.
- Flush mid-word: 2 beats accepted, then `flush_i` for one cycle -> `cnt=0`; the next 4 beats 0x01..0x04 yield `data_o=0x04030201`.
- Async reset: assert `rst_i` between clock edges with `valid_o=1` -> `valid_o`, `strb_o` and `last_o` drop to 0 immediately; after release, normal packing resumes.
- Randomized: the FIFO stage is driven upstream with random valid/ready at 1/10 probability for 1000 elements -> the unpacked sequence equals the applied sequence, with zero mismatches.
